// File: rtl/detector_stream_controller.sv
// Serialises parallel test words into a 01[0*]1 sequence detector, MSB first,
// and counts the detector's z pulses per word with a saturating hit counter.
module detector_stream_controller #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             clear_det,
    input  logic             pause,
    output logic             det_rst,
    output logic             det_ena,
    output logic             det_bit,
    input  logic             det_z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] accept_len;
    logic             shifting;

    // Oversized lengths are clamped to the full word.
    assign accept_len = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;

    // Detector-side strobes decode the state directly so reset takes effect at once.
    assign shifting   = ~rst & (state == SHIFT);
    assign load_ready = ~rst & (state == IDLE);
    assign busy       = ~rst & (state != IDLE);
    assign done       = ~rst & (state == DONE);
    assign det_rst    = rst | (state == CLEAR);
    assign det_ena    = shifting & ~pause;
    assign det_bit    = shifting ? shreg[WIDTH-1] : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            remaining <= '0;
            hit_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        // Left-justify so the first bit to send sits in the MSB.
                        shreg     <= load_data << (LEN_W'(WIDTH) - accept_len);
                        remaining <= accept_len;
                        hit_count <= '0;
                        if (accept_len == '0) begin
                            state <= DONE;
                        end else if (clear_det) begin
                            state <= CLEAR;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                CLEAR: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (!pause) begin
                        shreg     <= shreg << 1;
                        remaining <= remaining - LEN_W'(1);
                        if (det_z && (hit_count != {CNT_W{1'b1}})) begin
                            hit_count <= hit_count + CNT_W'(1);
                        end
                        if (remaining == LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_detector_stream_controller.sv
// Directed bench for detector_stream_controller: two instances (8-bit and 2-bit
// hit counters) share stimulus, each driving its own behavioural 01[0*]1 detector.
module tb_detector_stream_controller;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic [LEN_W-1:0] load_len = '0;
    logic             clear_det = 1'b0;
    logic             pause = 1'b0;

    logic [1:0] load_ready, det_rst, det_ena, det_bit, det_z, busy, done;
    logic [7:0] hc0;
    logic [1:0] hc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    detector_stream_controller #(.WIDTH(WIDTH), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready[0]),
        .load_data(load_data), .load_len(load_len), .clear_det(clear_det), .pause(pause),
        .det_rst(det_rst[0]), .det_ena(det_ena[0]), .det_bit(det_bit[0]), .det_z(det_z[0]),
        .busy(busy[0]), .done(done[0]), .hit_count(hc0)
    );

    detector_stream_controller #(.WIDTH(WIDTH), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready[1]),
        .load_data(load_data), .load_len(load_len), .clear_det(clear_det), .pause(pause),
        .det_rst(det_rst[1]), .det_ena(det_ena[1]), .det_bit(det_bit[1]), .det_z(det_z[1]),
        .busy(busy[1]), .done(done[1]), .hit_count(hc1)
    );

    // Detector model: z when the bit is 1 and the previous 1 was itself preceded by a 0.
    logic [1:0] m_have_prev, m_last, m_have_one, m_pre0;

    assign det_z = det_ena & det_bit & m_have_one & m_pre0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (det_rst[i]) begin
                m_have_prev[i] <= 1'b0;
                m_last[i]      <= 1'b0;
                m_have_one[i]  <= 1'b0;
                m_pre0[i]      <= 1'b0;
            end else if (det_ena[i]) begin
                if (det_bit[i]) begin
                    m_have_one[i] <= 1'b1;
                    m_pre0[i]     <= m_have_prev[i] & ~m_last[i];
                end
                m_have_prev[i] <= 1'b1;
                m_last[i]      <= det_bit[i];
            end
        end
    end

    // Offers one word, then observes dut0 cycle by cycle (cycle 1 = first after accept).
    task automatic run_word(
        input  logic [15:0] data, input logic [4:0] len, input logic clr,
        input  int p_start, input int p_len, input logic hold_valid,
        output int done_cyc, output int ena_cnt, output int rst_cnt,
        output logic [31:0] bits, output int pause_ena, output int z_cnt,
        output int ready_busy
    );
        done_cyc = 0; ena_cnt = 0; rst_cnt = 0; bits = '0;
        pause_ena = 0; z_cnt = 0; ready_busy = 0;
        load_data = data; load_len = len; clear_det = clr; load_valid = 1'b1;
        @(posedge clk); #1;
        if (hold_valid) load_data = ~data;
        else load_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            pause = (cyc >= p_start) && (cyc < p_start + p_len);
            #1;
            if (det_rst[0]) rst_cnt++;
            if (det_ena[0]) begin
                ena_cnt++;
                bits = {bits[30:0], det_bit[0]};
                if (det_z[0]) z_cnt++;
            end
            if (pause && det_ena[0]) pause_ena++;
            if (load_ready[0]) ready_busy++;
            if (done[0]) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        pause = 1'b0;
        load_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    int          d_cyc, e_cnt, r_cnt, p_ena, z_cnt, rdy_b;
    logic [31:0] bits;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({done[0], det_ena[0], det_bit[0], busy[0], det_rst[0]} !== 5'b00101) begin
            errors++;
            $display("FAIL reset_outputs: done,ena,bit,busy,rst got %b expected 00101",
                     {done[0], det_ena[0], det_bit[0], busy[0], det_rst[0]});
        end
        checks++;
        if (hc0 !== 8'd0) begin
            errors++;
            $display("FAIL reset_hit_count: got %0d expected 0", hc0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({load_ready[0], busy[0], det_rst[0]} !== 3'b100) begin
            errors++;
            $display("FAIL idle_outputs: ready,busy,det_rst got %b expected 100",
                     {load_ready[0], busy[0], det_rst[0]});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_word(16'h0005, 5'd4, 1'b1, 0, 0, 1'b0, d_cyc, e_cnt, r_cnt, bits, p_ena, z_cnt, rdy_b);
        checks++;
        if (r_cnt !== 1 || e_cnt !== 4) begin
            errors++;
            $display("FAIL basic_rst_ena: det_rst cycles %0d ena cycles %0d expected 1 and 4", r_cnt, e_cnt);
        end
        checks++;
        if (bits !== 32'h5) begin
            errors++;
            $display("FAIL basic_bits: got %b expected 0101", bits[3:0]);
        end
        checks++;
        if (d_cyc !== 6) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d expected 6", d_cyc);
        end
        checks++;
        if (hc0 !== 8'd1 || z_cnt !== 1) begin
            errors++;
            $display("FAIL basic_hits: hit_count %0d raw z %0d expected 1 and 1", hc0, z_cnt);
        end
        checks++;
        if (rdy_b !== 0) begin
            errors++;
            $display("FAIL basic_ready_busy: load_ready high %0d busy cycles expected 0", rdy_b);
        end
    endtask

    task automatic test_multi_hit();
        run_word(16'h006B, 5'd8, 1'b1, 0, 0, 1'b0, d_cyc, e_cnt, r_cnt, bits, p_ena, z_cnt, rdy_b);
        checks++;
        if (bits !== 32'h6B || e_cnt !== 8) begin
            errors++;
            $display("FAIL multi_bits: got %h over %0d cycles expected 6b over 8", bits, e_cnt);
        end
        checks++;
        if (d_cyc !== 10 || hc0 !== 8'd3) begin
            errors++;
            $display("FAIL multi_result: done cycle %0d hit_count %0d expected 10 and 3", d_cyc, hc0);
        end
    endtask

    task automatic test_pause();
        run_word(16'h006B, 5'd8, 1'b1, 4, 3, 1'b0, d_cyc, e_cnt, r_cnt, bits, p_ena, z_cnt, rdy_b);
        checks++;
        if (p_ena !== 0 || e_cnt !== 8) begin
            errors++;
            $display("FAIL pause_ena: ena during pause %0d total ena %0d expected 0 and 8", p_ena, e_cnt);
        end
        checks++;
        if (d_cyc !== 13 || hc0 !== 8'd3 || bits !== 32'h6B) begin
            errors++;
            $display("FAIL pause_result: done %0d hits %0d bits %h expected 13, 3, 6b", d_cyc, hc0, bits);
        end
    endtask

    task automatic test_len_bounds();
        run_word(16'hFFFF, 5'd0, 1'b1, 0, 0, 1'b0, d_cyc, e_cnt, r_cnt, bits, p_ena, z_cnt, rdy_b);
        checks++;
        if (d_cyc !== 1 || e_cnt !== 0 || r_cnt !== 0 || hc0 !== 8'd0) begin
            errors++;
            $display("FAIL len_zero: done %0d ena %0d rst %0d hits %0d expected 1,0,0,0",
                     d_cyc, e_cnt, r_cnt, hc0);
        end
        run_word(16'h8005, 5'd20, 1'b1, 0, 0, 1'b0, d_cyc, e_cnt, r_cnt, bits, p_ena, z_cnt, rdy_b);
        checks++;
        if (e_cnt !== 16 || bits !== 32'h8005) begin
            errors++;
            $display("FAIL len_clamp: ena %0d bits %h expected 16 and 8005", e_cnt, bits);
        end
        checks++;
        if (d_cyc !== 18 || hc0 !== 8'd1) begin
            errors++;
            $display("FAIL len_clamp_result: done %0d hits %0d expected 18 and 1", d_cyc, hc0);
        end
    endtask

    task automatic test_saturate();
        run_word(16'h5555, 5'd16, 1'b1, 0, 0, 1'b0, d_cyc, e_cnt, r_cnt, bits, p_ena, z_cnt, rdy_b);
        checks++;
        if (hc0 !== 8'd7 || z_cnt !== 7) begin
            errors++;
            $display("FAIL sat_wide: hit_count %0d raw z %0d expected 7 and 7", hc0, z_cnt);
        end
        checks++;
        if (hc1 !== 2'd3) begin
            errors++;
            $display("FAIL sat_narrow: hit_count %0d expected 3", hc1);
        end
    endtask

    // No clear: detector history from the previous word (...01) carries over.
    task automatic test_no_clear();
        run_word(16'h0005, 5'd4, 1'b0, 0, 0, 1'b0, d_cyc, e_cnt, r_cnt, bits, p_ena, z_cnt, rdy_b);
        checks++;
        if (d_cyc !== 5 || r_cnt !== 0) begin
            errors++;
            $display("FAIL noclear_timing: done %0d det_rst cycles %0d expected 5 and 0", d_cyc, r_cnt);
        end
        checks++;
        if (hc0 !== 8'd2) begin
            errors++;
            $display("FAIL noclear_hits: got %0d expected 2", hc0);
        end
    endtask

    task automatic test_reset_abort();
        int done_seen;
        load_data = 16'h0040; load_len = 5'd8; clear_det = 1'b0; load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (hc0 !== 8'd1 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: hit_count %0d busy %b expected 1 and 1", hc0, busy[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({det_rst[0], det_ena[0], busy[0], done[0]} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_in_reset: det_rst,ena,busy,done got %b expected 1000",
                     {det_rst[0], det_ena[0], busy[0], done[0]});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (hc0 !== 8'd0 || load_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_post: hit_count %0d load_ready %b expected 0 and 1", hc0, load_ready[0]);
        end
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done[0] || busy[0]) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: done/busy seen %0d cycles expected 0", done_seen);
        end
    endtask

    task automatic test_back_to_back();
        run_word(16'h0005, 5'd4, 1'b0, 0, 0, 1'b1, d_cyc, e_cnt, r_cnt, bits, p_ena, z_cnt, rdy_b);
        checks++;
        if (rdy_b !== 0 || d_cyc !== 5 || e_cnt !== 4) begin
            errors++;
            $display("FAIL busy_ignore: ready %0d done %0d ena %0d expected 0, 5, 4", rdy_b, d_cyc, e_cnt);
        end
        checks++;
        if (bits !== 32'h5 || hc0 !== 8'd1) begin
            errors++;
            $display("FAIL busy_ignore_data: bits %h hits %0d expected 5 and 1", bits, hc0);
        end
        checks++;
        if (busy[0] !== 1'b0 || load_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_return_idle: busy %b ready %b expected 0 and 1", busy[0], load_ready[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_hit();
        test_pause();
        test_len_bounds();
        test_saturate();
        test_no_clear();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
